// File: rtl/planificador_sensores_if.sv
`default_nettype none
// ============================================================================
//  Module      : planificador_sensores_if
//  Description : Result port of the sensor scheduler (valid/ready + payload).
//  Revision    : 1.0 - initial release
// ============================================================================
interface planificador_sensores_if #(
    parameter int CNT_W = 32
);
    logic             result_valid;
    logic             result_ready;
    logic [2:0]       result_ch;
    logic [CNT_W-1:0] result_count;
    logic [2:0]       result_code;

    modport master (
        output result_valid,
        output result_ch,
        output result_count,
        output result_code,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_ch,
        input  result_count,
        input  result_code,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/planificador_sensores.sv
`default_nettype none
// ============================================================================
//  Module      : planificador_sensores
//  Description : Round-robin falling-edge measurement scheduler for NUM_CH
//                sensor lines; optional channel mask via PLANIFICADOR_MASK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module planificador_sensores #(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 32,
    parameter int CODE_STEP     = 5
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     enable,
    input  wire  [NUM_CH-1:0]       sensor,
`ifdef PLANIFICADOR_MASK_EN
    input  wire  [NUM_CH-1:0]       ch_mask,
`endif
    planificador_sensores_if.master res,
    output logic [3*NUM_CH-1:0]     codes,
    output logic [2:0]              ch_sel,
    output logic                    busy
);

    localparam int c_TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETTLE  = 2'd1;
    localparam logic [1:0] c_MEASURE = 2'd2;
    localparam logic [1:0] c_LATCH   = 2'd3;

    logic [1:0]          r_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]    r_count;
    logic                r_sync1, r_sync2, r_prev;
    logic [2:0]          r_ch_sel;
    logic                r_valid;
    logic [2:0]          r_res_ch;
    logic [CNT_W-1:0]    r_res_count;
    logic [2:0]          r_res_code;
    logic [3*NUM_CH-1:0] r_codes;

    logic [7:0]          w_sensor_ext;
    logic                w_edge;
    logic [CNT_W-1:0]    w_count_inc;
    logic [2:0]          w_next_ch;
    logic                w_any_ch;
    logic                w_cur_ok;
    logic                w_start;

    // Pad to 8 lanes so a 3-bit channel index is always in range.
    always_comb begin
        w_sensor_ext               = '1;
        w_sensor_ext[NUM_CH-1:0]   = sensor;
    end

`ifdef PLANIFICADOR_MASK_EN
    logic [7:0] w_mask_ext;
    logic [3:0] w_idx;
    logic       w_found;

    // Upward search with wrap for the next enabled channel after ch_sel.
    always_comb begin
        w_mask_ext             = '0;
        w_mask_ext[NUM_CH-1:0] = ch_mask;
        w_next_ch              = r_ch_sel;
        w_found                = 1'b0;
        w_idx                  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = {1'b0, r_ch_sel} + 4'(i);
            if (w_idx >= 4'(NUM_CH))
                w_idx = w_idx - 4'(NUM_CH);
            if (!w_found && w_mask_ext[w_idx[2:0]]) begin
                w_next_ch = w_idx[2:0];
                w_found   = 1'b1;
            end
        end
    end
    assign w_any_ch = |ch_mask;
    assign w_cur_ok = w_mask_ext[r_ch_sel];
`else
    assign w_next_ch = (r_ch_sel == 3'(NUM_CH - 1)) ? 3'd0 : r_ch_sel + 3'd1;
    assign w_any_ch  = 1'b1;
    assign w_cur_ok  = 1'b1;
`endif

    assign w_start     = enable & w_any_ch;
    assign w_edge      = r_prev & ~r_sync2;
    assign w_count_inc = (w_edge && (r_count != {CNT_W{1'b1}})) ? r_count + CNT_W'(1) : r_count;

    // Threshold compare chain: code k once count reaches k*CODE_STEP, capped at 7.
    function automatic logic [2:0] quantise(input logic [CNT_W-1:0] cnt);
        logic [2:0] q;
        q = 3'd0;
        for (int k = 1; k <= 7; k++)
            if (cnt >= CNT_W'(k * CODE_STEP))
                q = 3'(k);
        return q;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= w_sensor_ext[r_ch_sel];
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            r_ch_sel    <= '0;
            r_valid     <= 1'b0;
            r_res_ch    <= '0;
            r_res_count <= '0;
            r_res_code  <= '0;
            r_codes     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_timer <= '0;
                    r_count <= '0;
                    if (w_start) begin
                        r_state <= c_SETTLE;
                        if (!w_cur_ok)
                            r_ch_sel <= w_next_ch;
                    end
                end
                c_SETTLE: begin
                    r_count <= '0;
                    if (!enable) begin
                        r_state <= c_IDLE;
                        r_timer <= '0;
                    end else if (r_timer == c_TMR_W'(SETTLE_CYCLES - 1)) begin
                        r_state <= c_MEASURE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                c_MEASURE: begin
                    if (!enable) begin
                        r_state <= c_IDLE;
                        r_timer <= '0;
                        r_count <= '0;
                    end else if (r_timer == c_TMR_W'(WINDOW_CYCLES - 1)) begin
                        // Final cycle's edge is folded into the latched result.
                        r_state     <= c_LATCH;
                        r_timer     <= '0;
                        r_count     <= w_count_inc;
                        r_valid     <= 1'b1;
                        r_res_count <= w_count_inc;
                        r_res_code  <= quantise(w_count_inc);
                        r_res_ch    <= r_ch_sel;
                    end else begin
                        r_count <= w_count_inc;
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                default: begin
                    if (res.result_ready) begin
                        r_valid  <= 1'b0;
                        r_count  <= '0;
                        r_ch_sel <= w_next_ch;
                        for (int i = 0; i < NUM_CH; i++)
                            if (r_res_ch == 3'(i))
                                r_codes[3*i +: 3] <= r_res_code;
                        r_state  <= (enable && w_any_ch) ? c_SETTLE : c_IDLE;
                    end
                end
            endcase
        end
    end

    assign res.result_valid = r_valid;
    assign res.result_ch    = r_res_ch;
    assign res.result_count = r_res_count;
    assign res.result_code  = r_res_code;
    assign codes            = r_codes;
    assign ch_sel           = r_ch_sel;
    assign busy             = (r_state != c_IDLE);

endmodule
`default_nettype wire
